sm_trace_buffer: RTL and testbench
==================================

// Module: sm_trace_buffer
// PURPOSE
//  Retirement-trace capture block. Sits directly downstream of sm_cpu next to sm_top.
//  Each cpu clock it records {pc, instr, a0} into a circular buffer.
//  On a halt instruction or a cycle timeout it freezes capture.
//  It then drains the most recent DEPTH entries over a valid/ready port to the bench or a debug UART.
// PARAMETERS
//  DEPTH      16            entries held; power of two, >=2
//  AW         $clog2(DEPTH) pointer width (derived, do not override)
//  TIMEOUT    120           captured cycles before forced stop (1..2^16-1)
//  HALT_INSTR 32'h00000063  beq zero,zero,0 (self-loop) = program end
// PORTS
//  clk        in   1   cpu clock (bypassed divider output)
//  rst_n      in   1   async active-low reset
//  clear      in   1   sync: flush buffer, return to IDLE
//  en         in   1   capture enable (cpu running, clkEnable)
//  pc         in   32  sm_cpu.pc of instruction in flight
//  instr      in   32  sm_cpu.instr
//  a0         in   32  rf[10] value this cycle
//  rd_valid   out  1   entry available on rd_data
//  rd_ready   in   1   consumer accepts entry
//  rd_data    out  96  {pc, instr, a0} of oldest entry
//  rd_last    out  1   rd_data is final entry
//  halted     out  1   stop caused by HALT_INSTR
//  timeout    out  1   stop caused by TIMEOUT
//  cycles     out  16  captured-cycle count
//  busy       out  1   state is CAPTURE or DRAIN
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; all pointers, count and cycles =0.
//   - rd_valid=0, rd_last=0, halted=0, timeout=0, busy=0, rd_data=0.
//  FSM: IDLE -> CAPTURE -> DRAIN -> DONE.
//   - IDLE: first cycle with en=1 is captured and moves to CAPTURE.
//   - CAPTURE, per en=1 cycle:
//     - write mem[wr_ptr]; wr_ptr++ (wraps at DEPTH); cycles++.
//     - count<DEPTH: count++.
//     - count==DEPTH: rd_ptr++ (overwrite oldest; count stays DEPTH).
//   - en=0 cycles: no write, no count; the timeout counter pauses.
//   - Trigger, evaluated on the entry being written:
//     - instr==HALT_INSTR: set halted, go to DRAIN; the halt entry IS stored.
//     - else cycles+1==TIMEOUT: set timeout, go to DRAIN; the entry is stored.
//     - Both true in one cycle: halted=1, timeout=0 (halt has priority).
//   - DRAIN:
//     - rd_valid = count!=0; rd_data = mem[rd_ptr] (comb read of reg array); rd_last = count==1.
//     - Pop on rd_valid&&rd_ready: rd_ptr++, count--.
//     - rd_data is held stable while rd_valid && !rd_ready.
//     - Pop of last entry -> DONE; the next cycle has rd_valid=0.
//   - DONE: outputs frozen, halted/timeout held; leaves only on clear or rst_n.
//  clear (any state): same values as reset, applied next edge; clear has priority over capture/pop.
//  Latency: entry written at edge N becomes drainable from the edge that enters DRAIN.
//  Zero-cycle bubble between pops: back-to-back pops with rd_ready held high.
//  rst_n low mid-DRAIN: immediate abort; buffer contents discarded.
//  Repeated HALT_INSTR (self-loop): only the first occurrence is captured.
//  cycles saturates at 16'hFFFF; TIMEOUT < 2^16, so saturation never masks the trigger.
// STRUCTURE
//  - Shared header sm_trace.vh:
//    - state encodings TR_IDLE/TR_CAPTURE/TR_DRAIN/TR_DONE.
//    - TR_ENTRY_W=96.
//    - default HALT_INSTR.
//  - Sub-module sm_trace_ram: DEPTH x 96 register array, 1 sync write port, 1 async read port.
//  - Top: FSM, pointers, counters, flags.
// TESTING
//  1 Reset: rst_n=0 for 4 clk -> all outputs 0, busy=0; en ignored while in reset.
//  2 Halt short program:
//    - Stimulus: 5 en cycles, pc 0,4,8,c,10; instr at pc=10 is 00000063; rd_ready=1.
//    - Required: halted=1, timeout=0, cycles=5.
//    - Required: 5 pops in pc order 0..10; rd_last on pc=10; then DONE.
//  3 Wrap/overwrite:
//    - Stimulus: DEPTH=16, 20 cycles, halt at cycle 20.
//    - Required: drain yields entries 5..20 (16 entries); first pc=0x10.
//  4 Timeout:
//    - Stimulus: TIMEOUT=120, no halt instruction.
//    - Required: timeout=1 after cycle 120; halted=0; last drained pc = pc of cycle 120.
//  5 Backpressure:
//    - Stimulus: rd_ready toggles 1,0,0,1...
//    - Required: rd_data stable while stalled; no entry lost or duplicated.
//    - Required: en=0 gaps during CAPTURE do not advance cycles.
//  6 Corner cases:
//    - Halt and timeout in the same cycle -> halted=1, timeout=0.
//    - clear mid-DRAIN -> next cycle IDLE, rd_valid=0, cycles=0.

Source files
------------

// File: rtl/sm_trace_buffer_pkg.sv
// Shared definitions for the retirement-trace buffer: FSM encodings, entry width, default halt opcode.
package sm_trace_buffer_pkg;

    typedef enum logic [1:0] {
        TR_IDLE    = 2'd0,
        TR_CAPTURE = 2'd1,
        TR_DRAIN   = 2'd2,
        TR_DONE    = 2'd3
    } tr_state_e;

    localparam int          TR_ENTRY_W            = 96;
    // beq zero,zero,0: the self-loop the programs end on
    localparam logic [31:0] TR_HALT_INSTR_DEFAULT = 32'h0000_0063;

endpackage

// File: rtl/sm_trace_buffer_ram.sv
// DEPTH x TR_ENTRY_W register array: one synchronous write port, one combinational read port.
module sm_trace_buffer_ram
    import sm_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [TR_ENTRY_W-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [TR_ENTRY_W-1:0] rdata
);

    logic [TR_ENTRY_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset; validity is tracked by count, so clearing
    // storage would only cost a reset tree across every bit.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sm_trace_buffer.sv
// Retirement-trace capture: records {pc, instr, a0} each enabled cycle into a circular
// buffer, freezes on halt or timeout, then drains the newest DEPTH entries over valid/ready.
module sm_trace_buffer
    import sm_trace_buffer_pkg::*;
#(
    parameter int          DEPTH      = 16,
    parameter int          TIMEOUT    = 120,
    parameter logic [31:0] HALT_INSTR = TR_HALT_INSTR_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  en,
    input  logic [31:0]           pc,
    input  logic [31:0]           instr,
    input  logic [31:0]           a0,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [TR_ENTRY_W-1:0] rd_data,
    output logic                  rd_last,
    output logic                  halted,
    output logic                  timeout,
    output logic [15:0]           cycles,
    output logic                  busy
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] FULL      = (AW + 1)'(DEPTH);
    localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

    tr_state_e             state, state_next;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic [TR_ENTRY_W-1:0] ram_rdata;

    logic capture, pop, hit_halt, hit_timeout, trigger;

    assign capture     = en && !clear && (state == TR_IDLE || state == TR_CAPTURE);
    assign hit_halt    = (instr == HALT_INSTR);
    // Halt wins when both fire on the same entry.
    assign hit_timeout = !hit_halt && (({1'b0, cycles} + 17'd1) == TIMEOUT_W);
    assign trigger     = hit_halt || hit_timeout;

    assign rd_valid = (state == TR_DRAIN) && (count != '0);
    assign rd_last  = rd_valid && (count == (AW + 1)'(1));
    assign rd_data  = rd_valid ? ram_rdata : '0;
    assign pop      = rd_valid && rd_ready;
    assign busy     = (state == TR_CAPTURE) || (state == TR_DRAIN);

    sm_trace_buffer_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (capture),
        .waddr (wr_ptr),
        .wdata ({pc, instr, a0}),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TR_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets its default first so no path through the case
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            TR_IDLE, TR_CAPTURE: begin
                if (capture) begin
                    state_next = trigger ? TR_DRAIN : TR_CAPTURE;
                end
            end
            TR_DRAIN: begin
                if (count == '0 || (pop && count == (AW + 1)'(1))) begin
                    state_next = TR_DONE;
                end
            end
            TR_DONE: state_next = TR_DONE;
            default: state_next = TR_IDLE;
        endcase
        if (clear) begin
            state_next = TR_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            cycles  <= '0;
            halted  <= 1'b0;
            timeout <= 1'b0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            cycles  <= '0;
            halted  <= 1'b0;
            timeout <= 1'b0;
        end else if (capture) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (cycles != 16'hFFFF) begin
                cycles <= cycles + 16'd1;
            end
            // A full buffer drops its oldest entry to make room.
            if (count == FULL) begin
                rd_ptr <= rd_ptr + 1'b1;
            end else begin
                count <= count + 1'b1;
            end
            if (hit_halt) begin
                halted <= 1'b1;
            end else if (hit_timeout) begin
                timeout <= 1'b1;
            end
        end else if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_sm_trace_buffer.sv
// Directed bench for sm_trace_buffer: halt, wrap, timeout, backpressure and clear/reset corners.
module tb_sm_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        en;
    logic [31:0] pc, instr, a0;
    logic        rd_valid, rd_ready, rd_last, halted, timeout, busy;
    logic [95:0] rd_data;
    logic [15:0] cycles;

    int n_vec = 0;
    int n_err = 0;

    logic [95:0] model[$];

    localparam logic [31:0] HALT = 32'h0000_0063;

    sm_trace_buffer #(
        .DEPTH      (16),
        .TIMEOUT    (120),
        .HALT_INSTR (HALT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .en       (en),
        .pc       (pc),
        .instr    (instr),
        .a0       (a0),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .halted   (halted),
        .timeout  (timeout),
        .cycles   (cycles),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect1(input string name, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic expect16(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Non-halting filler opcode derived from pc; low 12 bits 0x013 never match HALT.
    function automatic logic [31:0] nop_for(input logic [31:0] p);
        return {p[19:0], 12'h013};
    endfunction

    task automatic capture(input logic [31:0] p, input logic [31:0] ins);
        en    = 1'b1;
        pc    = p;
        instr = ins;
        a0    = ~p ^ 32'h5A5A_0000;
        model.push_back({p, ins, ~p ^ 32'h5A5A_0000});
        if (model.size() > 16) void'(model.pop_front());
        step();
        en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model.delete();
    endtask

    // stall_mode 0: rd_ready always high; 1: rd_ready follows 1,0,0,1,0,0...
    task automatic drain_check(input string tag, input int stall_mode);
        logic [95:0] held;
        logic        stalled;
        int          k;
        int          guard;
        bit          stop;
        held    = '0;
        stalled = 1'b0;
        k       = 0;
        guard   = 0;
        stop    = 0;
        while (model.size() != 0 && guard < 400 && !stop) begin
            guard++;
            if (!rd_valid) begin
                n_vec++;
                n_err++;
                $display("FAIL %s valid: got 0 expected 1 with %0d entries left", tag, model.size());
                stop = 1;
            end else begin
                n_vec++;
                if (rd_data !== model[0]) begin
                    n_err++;
                    $display("FAIL %s data: got %h expected %h", tag, rd_data, model[0]);
                end
                expect1({tag, " last"}, rd_last, model.size() == 1);
                if (stalled) begin
                    n_vec++;
                    if (rd_data !== held) begin
                        n_err++;
                        $display("FAIL %s hold: got %h expected %h", tag, rd_data, held);
                    end
                end
                rd_ready = (stall_mode == 0) ? 1'b1 : (k % 3 == 0);
                k++;
                held    = rd_data;
                stalled = !rd_ready;
                if (rd_ready) void'(model.pop_front());
                step();
            end
        end
        if (guard >= 400) begin
            n_vec++;
            n_err++;
            $display("FAIL %s drain bound: got %0d left expected 0", tag, model.size());
        end
        rd_ready = 1'b0;
        expect1({tag, " done valid"}, rd_valid, 1'b0);
        expect1({tag, " done busy"}, busy, 1'b0);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        clear    = 1'b0;
        rd_ready = 1'b0;
        en       = 1'b1;
        pc       = 32'h40;
        instr    = HALT;
        a0       = 32'h1;
        repeat (4) step();
        expect1("rst valid", rd_valid, 1'b0);
        expect1("rst last", rd_last, 1'b0);
        expect1("rst halted", halted, 1'b0);
        expect1("rst timeout", timeout, 1'b0);
        expect1("rst busy", busy, 1'b0);
        expect16("rst cycles", cycles, 16'd0);
        n_vec++;
        if (rd_data !== 96'd0) begin
            n_err++;
            $display("FAIL rst data: got %h expected 0", rd_data);
        end
        en    = 1'b0;
        rst_n = 1'b1;
        step();
        expect1("post-rst busy", busy, 1'b0);
        expect16("post-rst cycles", cycles, 16'd0);
    endtask

    task automatic test_halt_short();
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) capture(32'(i * 4), nop_for(32'(i * 4)));
        expect1("halt busy mid", busy, 1'b1);
        capture(32'h10, HALT);
        rd_ready = 1'b0;
        expect1("halt halted", halted, 1'b1);
        expect1("halt timeout", timeout, 1'b0);
        expect16("halt cycles", cycles, 16'd5);
        n_vec++;
        if (rd_data[95:64] !== 32'h0) begin
            n_err++;
            $display("FAIL halt first pc: got %h expected 00000000", rd_data[95:64]);
        end
        drain_check("halt", 0);
        expect1("halt done held", halted, 1'b1);
        do_clear();
        expect1("halt clear halted", halted, 1'b0);
    endtask

    task automatic test_wrap();
        for (int i = 1; i < 20; i++) capture(32'((i - 1) * 4), nop_for(32'((i - 1) * 4)));
        capture(32'h4C, HALT);
        expect16("wrap cycles", cycles, 16'd20);
        n_vec++;
        if (rd_data[95:64] !== 32'h10) begin
            n_err++;
            $display("FAIL wrap first pc: got %h expected 00000010", rd_data[95:64]);
        end
        drain_check("wrap", 0);
        do_clear();
    endtask

    task automatic test_timeout();
        for (int i = 1; i < 120; i++) capture(32'((i - 1) * 4), nop_for(32'((i - 1) * 4)));
        expect1("to before", timeout, 1'b0);
        expect1("to before valid", rd_valid, 1'b0);
        capture(32'h1DC, nop_for(32'h1DC));
        expect1("to timeout", timeout, 1'b1);
        expect1("to halted", halted, 1'b0);
        expect16("to cycles", cycles, 16'd120);
        n_vec++;
        if (model[model.size() - 1][95:64] !== 32'h1DC) begin
            n_err++;
            $display("FAIL to model tail: got %h expected 000001dc", model[model.size() - 1][95:64]);
        end
        drain_check("to", 0);
        do_clear();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 6; i++) begin
            capture(32'h100 + 32'(i * 4), (i == 5) ? HALT : nop_for(32'h100 + 32'(i * 4)));
            if (i < 5) begin
                repeat (2) step();
                expect16("bp gap cycles", cycles, 16'(i + 1));
            end
        end
        expect16("bp cycles", cycles, 16'd6);
        drain_check("bp", 1);
        do_clear();
    endtask

    task automatic test_corners();
        for (int i = 1; i < 120; i++) capture(32'((i - 1) * 4), nop_for(32'((i - 1) * 4)));
        capture(32'h1DC, HALT);
        expect1("both halted", halted, 1'b1);
        expect1("both timeout", timeout, 1'b0);
        rd_ready = 1'b1;
        repeat (3) step();
        expect1("mid drain valid", rd_valid, 1'b1);
        clear = 1'b1;
        step();
        clear    = 1'b0;
        rd_ready = 1'b0;
        model.delete();
        expect1("clr valid", rd_valid, 1'b0);
        expect1("clr busy", busy, 1'b0);
        expect16("clr cycles", cycles, 16'd0);
        expect1("clr halted", halted, 1'b0);
        capture(32'h200, HALT);
        expect1("rst-drain valid before", rd_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        expect1("rst-drain valid", rd_valid, 1'b0);
        expect1("rst-drain busy", busy, 1'b0);
        step();
        rst_n = 1'b1;
        model.delete();
        step();
        expect16("rst-drain cycles", cycles, 16'd0);
    endtask

    initial begin
        test_reset();
        test_halt_short();
        test_wrap();
        test_timeout();
        test_backpressure();
        test_corners();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
